// File: rtl/div_radix2_pkg.sv
// rtl/div_radix2_pkg.sv - shared state encoding and handshake constants for the radix-2 divider
package div_radix2_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - iterative restoring divider answering the EX-stage start/ready handshake
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             signed_q;
  logic             dividend_neg;
  logic             quo_neg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] fix_rem;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // The remainder stays below the divisor, so only the shifted value needs the extra bit.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    step_rem = rem;
    step_quo = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      step_rem    = trial[WIDTH-1:0];
      step_quo[0] = 1'b1;
    end else begin
      step_rem = shifted[WIDTH-1:0];
    end
    fix_quo = (signed_q && quo_neg)      ? -step_quo : step_quo;
    fix_rem = (signed_q && dividend_neg) ? -step_rem : step_rem;
    abs_a   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs_b   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= DIV_FREE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      divisor      <= '0;
      signed_q     <= 1'b0;
      dividend_neg <= 1'b0;
      quo_neg      <= 1'b0;
      result_o     <= '0;
      ready_o      <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              state        <= DIV_ON;
              quo          <= abs_a;
              divisor      <= abs_b;
              rem          <= '0;
              cnt          <= '0;
              signed_q     <= signed_div_i;
              dividend_neg <= opdata1_i[WIDTH-1];
              quo_neg      <= opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1];
            end
          end
        end

        DIV_BYZERO: begin
          state    <= DIV_END;
          result_o <= '0;
          ready_o  <= DIV_RESULT_READY;
        end

        DIV_ON: begin
          if (annul_i || !start_i) begin
            state <= DIV_FREE;
          end else begin
            rem <= step_rem;
            quo <= step_quo;
            cnt <= cnt + 1'b1;
            // Final step: the sign-corrected result is registered on the same edge as END.
            if (cnt == LAST_STEP) begin
              state    <= DIV_END;
              result_o <= {fix_rem, fix_quo};
              ready_o  <= DIV_RESULT_READY;
            end
          end
        end

        DIV_END: begin
          if (annul_i || !start_i) begin
            state    <= DIV_FREE;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// tb/tb_div_radix2.sv - directed vector bench for div_radix2
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_radix2 #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  typedef struct {
    string       name;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          change_at;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_div(input vec_t v);
    int edges;
    int exp_lat;
    logic got;
    exp_lat    = (v.b == 32'd0) ? 2 : 33;
    signed_div = v.sg;
    opdata1    = v.a;
    opdata2    = v.b;
    start      = 1'b1;
    edges      = 0;
    got        = 1'b0;
    while (!got && edges < 40) begin
      @(negedge clk);
      edges++;
      if (edges == v.change_at) begin
        opdata1 = 32'd0;
        opdata2 = 32'd1;
      end
      if (ready) got = 1'b1;
    end
    check({v.name, " latency"}, 64'(edges), 64'(exp_lat));
    check({v.name, " result"}, result, {v.r, v.q});
    @(negedge clk);
    check({v.name, " hold"}, {63'd0, ready} ^ (result << 1), {63'd0, 1'b1} ^ ({v.r, v.q} << 1));
    start = 1'b0;
    @(negedge clk);
    check({v.name, " drop"}, {ready, result[62:0]}, 64'd0);
    @(negedge clk);
  endtask

  task automatic count_ready(input int cycles, output int highs);
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready) highs++;
    end
  endtask

  int highs;
  int edges;

  initial begin
    vecs[0]  = '{"divu_100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          -1};
    vecs[1]  = '{"div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   -1};
    vecs[2]  = '{"div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          -1};
    vecs[3]  = '{"div_ovf",       1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          -1};
    vecs[4]  = '{"divu_byzero",   1'b0, 32'h1234,       32'd0,          32'd0,          32'd0,          -1};
    vecs[5]  = '{"divu_max_1",    1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          -1};
    vecs[6]  = '{"divu_small",    1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          -1};
    vecs[7]  = '{"div_m100_7",    1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   -1};
    vecs[8]  = '{"divu_big_max",  1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   -1};
    vecs[9]  = '{"div_byzero",    1'b1, 32'hFFFFFFF0,   32'd0,          32'd0,          32'd0,          -1};
    vecs[10] = '{"div_m9_m3",     1'b1, 32'hFFFFFFF7,   32'hFFFFFFFD,   32'd3,          32'd0,          -1};
    vecs[11] = '{"hold_operands", 1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,           3};

    resetn = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    repeat (2) @(negedge clk);
    check("reset state", {ready, result[62:0]}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_div(vecs[i]);

    // annul at step 10 with start dropped: no result ever appears
    signed_div = 1'b0; opdata1 = 32'd123456; opdata2 = 32'd7; start = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    count_ready(40, highs);
    check("annul no ready", 64'(highs), 64'd0);

    run_div('{"restart_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, -1});

    // annul at step 10 with start kept high: the divide restarts from scratch
    opdata1 = 32'd123456; opdata2 = 32'd7; start = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    edges = 12;
    while (!ready && edges < 60) begin
      @(negedge clk);
      edges++;
    end
    check("annul restart latency", 64'(edges), 64'd45);
    check("annul restart result", result, {32'd4, 32'd17636});
    start = 1'b0;
    repeat (2) @(negedge clk);

    // annul and start together in FREE: nothing starts, not even a divide-by-zero
    opdata1 = 32'd55; opdata2 = 32'd0; start = 1'b1; annul = 1'b1;
    count_ready(4, highs);
    check("annul beats start", 64'(highs), 64'd0);
    start = 1'b0; annul = 1'b0;
    @(negedge clk);

    // reset in the middle of ON
    opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("reset mid-on", {ready, result[62:0]}, 64'd0);
    resetn = 1'b1; start = 1'b0;
    count_ready(40, highs);
    check("reset mid-on no ready", 64'(highs), 64'd0);

    run_div('{"after_reset", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, -1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_radix2.md
Name: div_radix2

Overview:
- Iterative 32-bit radix-2 restoring divider.
- Responder side of the EX-stage divide handshake (start_i / ready_o).
- Instantiated in EX. EX holds operands and start_i high while ready_o is low, and stalls the pipeline until ready_o rises.
- Result packs remainder (to HI) and quotient (to LO).

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH bits.

Ports:
- clk  input  1  clock, all state updates on posedge.
- resetn  input  1  synchronous active-low reset.
- signed_div_i  input  1  1 = signed (div), 0 = unsigned (divu); sampled with start.
- opdata1_i  input  32  dividend.
- opdata2_i  input  32  divisor.
- start_i  input  1  request. Held high by EX until ready_o is seen, then dropped.
- annul_i  input  1  abort the in-flight divide (flush); EX ties it to 0 today.
- result_o  output  64  {remainder[31:0], quotient[31:0]}; bits 63:32 go to HI, bits 31:0 go to LO.
- ready_o  output  1  result valid (DivResultReady).

Behaviour:
- Reset (resetn=0 at posedge): state=FREE, cnt=0, result_o=0, ready_o=0. Applies mid-operation; any in-flight divide is discarded.
- ready_o and result_o are registered. They are 0 in every state except END.
- States are FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, divisor==0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. At that edge latch: abs(dividend) and abs(divisor) if signed_div_i=1, else raw; signed_div_i; sign(opdata1_i); sign(opdata1_i)^sign(opdata2_i). Clear the 33-bit partial remainder; cnt=0.
  - Otherwise stay in FREE.
- BYZERO: next edge -> END with quotient=0, remainder=0.
- ON, one step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract: diff = rem - divisor (33-bit).
  - If diff is non-negative, rem=diff and the quotient LSB is 1; else the quotient LSB is 0.
  - cnt increments. When cnt==31 completes, go to END.
  - annul_i=1 or start_i=0 during ON -> FREE immediately, no result, ready_o stays 0.
- END:
  - Load the corrected result. Signed: negate the quotient if the sign bits differ; negate the remainder if the dividend was negative.
  - Set ready_o=1 and hold result_o stable while start_i=1.
  - start_i=0 -> FREE, clearing ready_o and result_o at that edge.
  - annul_i=1 -> FREE.
- Latency, counted from the first posedge that samples start_i=1 in FREE:
  - Nonzero divisor: ready_o is high in the cycle after edge 33, i.e. 33 cycles of stall.
  - Zero divisor: ready_o is high after 2 edges.
- Operand changes on opdata*_i after the start edge are ignored; the latched copies are used.
- Boundary cases:
  - -2^31 / -1 signed: quotient=0x80000000, rem=0 (two's-complement wrap, no trap).
  - Unsigned 0xFFFFFFFF/1: quo=0xFFFFFFFF, rem=0.
  - dividend < divisor: quo=0, rem=dividend.
- Back-to-back: if start_i is still high in the FREE cycle after END, a new divide starts. EX guarantees one idle cycle because it drops start when it consumes the result.
- annul_i and start_i both high in FREE: annul wins, no start.

Decomposition:
- Shared defines (lib/defines.vh) hold the constants:
  - DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivResultReady/NotReady, DivStart/DivStop, ZeroWord (existing).
- No sub-module; the abs/negate helpers are inline expressions. The state machine and datapath are a single always block plus a next-state block.

Test Plan:
- Unsigned: divu 100/7, start held -> ready_o rises after 33 edges. result_o={32'd2, 32'd14}, then drops one cycle after start_i falls.
- Signed: div -7/2 -> quo=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1).
- Signed: div 7/-2 -> quo=-3, rem=1.
- Overflow: div 0x80000000/0xFFFFFFFF -> quo=0x80000000, rem=0.
- Divide by zero: 0x1234/0 -> ready_o after 2 edges, result_o=64'h0.
- Abort and reset:
  - annul_i pulsed at step 10 -> state FREE, ready_o never rises.
  - Restart 9/3 -> {0, 3} after 33 edges.
  - resetn=0 mid-ON -> ready_o=0, result_o=0 next cycle.
- Operand hold: change opdata1_i to 0 during ON of 0xFFFFFFFF/0x10 -> result {0xF, 0x0FFFFFFF} unaffected.
